facq_prn_player: RTL and testbench
==================================

Name: facq_prn_player

Overview:
- Parametrised multi-tap PRN code player for the fast-acquisition path.
- Plays a bit-packed PRN sequence from a word RAM at a programmable samples-per-chip rate.
- Supports arbitrary bit-granular start phase, cyclic or one-shot playback, bit-order reversal, and a sample-spaced tap line for early/prompt/late correlators.
- Single clock domain; the RAM is loaded through a simple write port driven by the register-file wrapper.

Parameters:
- WORD_W, 32, RAM word width in bits (power of 2).
- DEPTH, 64, RAM depth in words; max code length is WORD_W*DEPTH bits.
- DIV_W, 3, width of the samples-per-chip divider.
- NTAP, 3, number of delayed PRN taps (sample spacing), NTAP >= 1.
- Localparams: AW = clog2(DEPTH), BW = clog2(WORD_W), LW = clog2(WORD_W*DEPTH+1).

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  RAM write strobe.
- wr_addr  in  AW  RAM write word address.
- wr_data  in  WORD_W  RAM write data.
- cfg_len  in  LW  code length in bits, 1..WORD_W*DEPTH.
- cfg_div  in  DIV_W  samples per chip; 0 is treated as 1.
- cfg_reverse  in  1  1 = MSB-first within a word, 0 = LSB-first.
- cfg_cyclic  in  1  1 = wrap at end of code, 0 = stop after one period.
- init  in  1  start/restart pulse.
- init_phase  in  LW  starting chip index.
- shift  in  1  sample strobe.
- prn  out  1  prompt PRN bit.
- prn_taps  out  NTAP  prn delayed by 1..NTAP samples; bit k = k+1 samples.
- valid  out  1  prn/prn_taps valid for this sample.
- epoch  out  1  pulse: the sample emitted is the first sample of chip 0.
- chip_idx  out  LW  chip index of the current prn.
- busy  out  1  state is LOAD0 or LOAD1.
- done  out  1  one-cycle pulse at the end of one-shot playback.

Behaviour:
- Reset: all outputs 0, taps 0, state IDLE, internal counters 0. rst overrides every other input. RAM contents are not cleared.
- RAM: simple dual-port, read-first, 1-cycle read latency. A same-address write and read return the old data.
- FSM states: IDLE, LOAD0, LOAD1, RUN, DONE.
  - init from any state goes to LOAD0; init has priority over shift.
  - init_phase >= cfg_len is treated as 0.
- LOAD0: issue a read of word p>>BW, where p is the effective phase. Set bit pointer = p[BW-1:0], chip counter = p, rep counter = 0.
- LOAD1: capture that word into the current register. Issue a read of the next word (word 0 if the current word is the last word (cfg_len-1)>>BW).
- Transition to RUN: capture the next word into the prefetch register. shift is ignored in LOAD0/LOAD1; busy = 1 there.
- RUN, each shift:
  - The rep counter increments. Chip advance occurs when rep == div-1; rep then returns to 0.
  - Outputs are registered, with 1-cycle latency from shift.
  - prn = current-register bit at position ptr, or WORD_W-1-ptr when cfg_reverse = 1.
  - valid = 1, chip_idx = chip counter, epoch = (chip counter == 0 && rep == 0).
  - prn_taps shift by one (tap0 <= previous prn) only on valid samples.
  - valid = 0 on cycles without shift in RUN. Outputs hold their values.
- Chip advance:
  - Normally ptr+1 and chip+1.
  - At ptr == WORD_W-1: current <= prefetch, then read the following word (wrap per the rule above). The prefetch register is refreshed next cycle.
  - At chip == cfg_len-1: chip <= 0, ptr <= 0, current <= prefetch (word 0).
    - cfg_cyclic = 1: stay in RUN.
    - cfg_cyclic = 0: go to DONE with a 1-cycle done pulse; valid stays 0 until the next init.
- cfg_div = 1 must sustain one chip per cycle with continuous shift, with no bubbles across word boundaries. The prefetch guarantees this.
- A partial last word: only bits 0..(cfg_len-1)%WORD_W are used.
- Config changes are only guaranteed after an init. A RAM write during RUN takes effect at the next fetch of that word.

Decomposition:
- Package facq_prn_pkg: state enum, wrap-address helper function, width localparams.
- Sub-module prn_word_ram: parametrised SDP RAM, 1-cycle read. The player FSM, counters, and tap line stay in facq_prn_player.

Test Plan:
- WORD_W=32, load 0xA5A5A5A5 and 0x0F0F0F0F; len=64, div=1, init phase 0, continuous shift -> prn = bits 1,0,1,0,0,1,0,1... LSB-first with no gap at chip 32. epoch on chip 0 every 64 samples after wrap.
- Same data, cfg_reverse=1 -> first 8 prn bits = 1,0,1,0,0,1,0,1 MSB-first (0xA5). Chip 32 begins 0,0,0,0,1,1,1,1.
- len=40, div=2, phase 37 -> chip_idx 37,37,38,38,39,39,0,0. epoch on the first sample of chip 0. Each bit is held for 2 samples.
- cfg_cyclic=0, len=5, div=1 -> exactly 5 valid samples, done pulse 1 cycle after the 5th, valid=0 thereafter until init.
- NTAP=3, alternating code 1,0 at div=1 -> prn_taps[0] = previous prn, prn_taps[2] = prn three samples earlier.
- rst asserted mid-RUN, and init asserted concurrently with shift -> rst: all outputs 0 next cycle, IDLE. init: busy for 2 cycles, shift ignored, first valid prn equals the bit at init_phase.

Source files
------------

// File: rtl/facq_prn_pkg.sv
// Shared definitions for the fast-acquisition PRN player.
// Contents:
//   - default widths for the player parameters
//   - state_t : player FSM state encoding
//   - wrap_next : next word index with wrap to 0 after the last word
package facq_prn_pkg;

  localparam int unsigned DEF_WORD_W = 32;
  localparam int unsigned DEF_DEPTH  = 64;
  localparam int unsigned DEF_DIV_W  = 3;
  localparam int unsigned DEF_NTAP   = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD0,
    ST_LOAD1,
    ST_RUN,
    ST_DONE
  } state_t;

  // Word index following 'cur' in a code whose final word is 'last'.
  function automatic int unsigned wrap_next(input int unsigned cur,
                                            input int unsigned last);
    return (cur >= last) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/facq_prn_player_ram.sv
// Simple dual-port code RAM, read-first, one-cycle registered read.
// Ports:
//   clk       : clock
//   i_wr_en   : write strobe
//   i_wr_addr : write word address
//   i_wr_data : write data
//   i_rd_addr : read word address (read every cycle)
//   o_rd_data : data at i_rd_addr from the previous cycle
module prn_word_ram #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Non-blocking write and read on the same edge give old data on a collision.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/facq_prn_player.sv
// Multi-tap PRN code player: plays a bit-packed code from word RAM at a
// programmable samples-per-chip rate with a sample-spaced tap line.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data        : code RAM write port
//   cfg_len/div/reverse/cyclic   : code length, samples/chip, bit order, wrap
//   init, init_phase             : (re)start at a given chip index
//   shift                        : sample strobe
//   prn, prn_taps, valid, epoch  : registered sample outputs
//   chip_idx, busy, done         : status
module facq_prn_player
  import facq_prn_pkg::*;
#(
  parameter int unsigned WORD_W = DEF_WORD_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DIV_W  = DEF_DIV_W,
  parameter int unsigned NTAP   = DEF_NTAP,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned BW    = $clog2(WORD_W),
  localparam int unsigned LW    = $clog2(WORD_W*DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [LW-1:0]     cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_reverse,
  input  logic              cfg_cyclic,
  input  logic              init,
  input  logic [LW-1:0]     init_phase,
  input  logic              shift,
  output logic              prn,
  output logic [NTAP-1:0]   prn_taps,
  output logic              valid,
  output logic              epoch,
  output logic [LW-1:0]     chip_idx,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [WORD_W-1:0] r_cur, r_pre;
  logic              r_pf_pend, r_arm;
  logic [AW-1:0]     r_word;
  logic [BW-1:0]     r_ptr;
  logic [LW-1:0]     r_chip;
  logic [DIV_W-1:0]  r_rep;

  logic [WORD_W-1:0] w_rd_data, w_pre;
  logic [AW-1:0]     w_rd_addr, w_last, w_word_nxt, w_word_nn, w_p_word;
  logic [LW-1:0]     w_lenm1, w_phase;
  logic [DIV_W-1:0]  w_divm1;
  logic [BW-1:0]     w_bit_idx;
  logic              w_step, w_adv, w_wrap, w_issue, w_bit;
  logic [NTAP:0]     w_tap_cat;

  prn_word_ram #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_lenm1    = cfg_len - LW'(1);
  assign w_last     = w_lenm1[BW+AW-1:BW];
  assign w_phase    = (init_phase >= cfg_len) ? '0 : init_phase;
  assign w_p_word   = w_phase[BW+AW-1:BW];
  assign w_divm1    = (cfg_div == '0) ? '0 : cfg_div - DIV_W'(1);
  assign w_word_nxt = AW'(wrap_next(32'(r_word), 32'(w_last)));
  assign w_word_nn  = AW'(wrap_next(32'(w_word_nxt), 32'(w_last)));

  assign w_step = (r_state == ST_RUN) && shift && !init;
  assign w_adv  = w_step && (r_rep == w_divm1);
  assign w_wrap = w_adv && (r_chip == w_lenm1);

  assign w_bit_idx = cfg_reverse ? ~r_ptr : r_ptr;
  assign w_bit     = r_cur[w_bit_idx];
  assign w_tap_cat = {prn_taps, prn};

  // A word fetched on a word advance lands one cycle later; w_pre forwards
  // that in-flight word so back-to-back advances (short last word, div=1)
  // never see a stale prefetch.
  assign w_pre = r_pf_pend ? w_rd_data : r_pre;

  always_comb begin
    w_rd_addr = r_word;
    w_issue   = 1'b0;
    if (!init && r_state == ST_LOAD1) begin
      w_rd_addr = w_word_nxt;
      w_issue   = 1'b1;
    end else if (w_adv && (w_wrap || r_ptr == '1)) begin
      w_rd_addr = w_word_nn;
      w_issue   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_pre     <= '0;
      r_pf_pend <= 1'b0;
      r_arm     <= 1'b0;
      r_word    <= '0;
      r_ptr     <= '0;
      r_chip    <= '0;
      r_rep     <= '0;
      prn       <= 1'b0;
      prn_taps  <= '0;
      valid     <= 1'b0;
      epoch     <= 1'b0;
      chip_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_pf_pend <= w_issue;
      r_pre     <= w_pre;
      done      <= r_arm;
      r_arm     <= 1'b0;
      if (init) begin
        r_state <= ST_LOAD0;
        busy    <= 1'b1;
        valid   <= 1'b0;
        epoch   <= 1'b0;
        r_word  <= w_p_word;
        r_ptr   <= w_phase[BW-1:0];
        r_chip  <= w_phase;
        r_rep   <= '0;
      end else begin
        case (r_state)
          ST_LOAD0: r_state <= ST_LOAD1;
          ST_LOAD1: begin
            r_cur   <= w_rd_data;
            r_state <= ST_RUN;
            busy    <= 1'b0;
          end
          ST_RUN: begin
            if (w_step) begin
              prn      <= w_bit;
              prn_taps <= w_tap_cat[NTAP-1:0];
              valid    <= 1'b1;
              chip_idx <= r_chip;
              epoch    <= (r_chip == '0) && (r_rep == '0);
              if (w_adv) begin
                r_rep <= '0;
                if (w_wrap) begin
                  r_chip <= '0;
                  r_ptr  <= '0;
                  r_cur  <= w_pre;
                  r_word <= w_word_nxt;
                  if (!cfg_cyclic) begin
                    r_state <= ST_DONE;
                    r_arm   <= 1'b1;
                  end
                end else if (r_ptr == '1) begin
                  r_chip <= r_chip + LW'(1);
                  r_ptr  <= '0;
                  r_cur  <= w_pre;
                  r_word <= w_word_nxt;
                end else begin
                  r_chip <= r_chip + LW'(1);
                  r_ptr  <= r_ptr + BW'(1);
                end
              end else begin
                r_rep <= r_rep + DIV_W'(1);
              end
            end else begin
              valid <= 1'b0;
              epoch <= 1'b0;
            end
          end
          default: begin
            valid <= 1'b0;
            epoch <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_facq_prn_player.sv
module tb_facq_prn_player;

  localparam int AW = 6;
  localparam int LW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [2:0]    cfg_div = '0;
  logic          cfg_reverse = 1'b0;
  logic          cfg_cyclic = 1'b0;
  logic          init = 1'b0;
  logic [LW-1:0] init_phase = '0;
  logic          shift = 1'b0;
  logic          prn;
  logic [2:0]    prn_taps;
  logic          valid;
  logic          epoch;
  logic [LW-1:0] chip_idx;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;
  logic [31:0] mem_model [64];

  facq_prn_player #(.WORD_W(32), .DEPTH(64), .DIV_W(3), .NTAP(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_len(cfg_len), .cfg_div(cfg_div), .cfg_reverse(cfg_reverse),
    .cfg_cyclic(cfg_cyclic), .init(init), .init_phase(init_phase),
    .shift(shift), .prn(prn), .prn_taps(prn_taps), .valid(valid),
    .epoch(epoch), .chip_idx(chip_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
    mem_model[a] = d;
  endtask

  function automatic logic model_bit(input int chip, input logic rev);
    logic [31:0] w;
    int p;
    w = mem_model[chip / 32];
    p = chip % 32;
    return rev ? w[31-p] : w[p];
  endfunction

  task automatic do_init(input int len, input int div, input logic rev,
                         input logic cyc, input int phase);
    cfg_len = LW'(len); cfg_div = 3'(div); cfg_reverse = rev;
    cfg_cyclic = cyc; init_phase = LW'(phase);
    init = 1'b1;
    step();
    init = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (prn !== 1'b0) begin bad++; $display("FAIL reset_prn got=%b exp=0", prn); end
    total++; if (prn_taps !== 3'b000) begin bad++; $display("FAIL reset_taps got=%b exp=000", prn_taps); end
    total++; if (chip_idx !== '0) begin bad++; $display("FAIL reset_chip got=%0d exp=0", chip_idx); end
    total++; if ({epoch, busy, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {epoch, busy, done}); end
  endtask

  task automatic test_lsb_cyclic();
    logic [7:0] hand;
    hand = 8'b10100101;
    shift = 1'b0;
    do_init(64, 1, 1'b0, 1'b1, 0);
    shift = 1'b1;
    for (int i = 0; i < 130; i++) begin
      step();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL lsb_valid i=%0d got=%b exp=1", i, valid); end
      total++; if (prn !== model_bit(i % 64, 1'b0)) begin bad++; $display("FAIL lsb_prn i=%0d got=%b exp=%b", i, prn, model_bit(i % 64, 1'b0)); end
      total++; if (chip_idx !== LW'(i % 64)) begin bad++; $display("FAIL lsb_chip i=%0d got=%0d exp=%0d", i, chip_idx, i % 64); end
      total++; if (epoch !== ((i % 64) == 0)) begin bad++; $display("FAIL lsb_epoch i=%0d got=%b exp=%b", i, epoch, (i % 64) == 0); end
      if (i < 8) begin
        total++; if (prn !== hand[7-i]) begin bad++; $display("FAIL lsb_hand i=%0d got=%b exp=%b", i, prn, hand[7-i]); end
      end
    end
    shift = 1'b0;
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL lsb_idle_valid got=%b exp=0", valid); end
  endtask

  task automatic test_reverse();
    logic [7:0] a5, f0;
    a5 = 8'b10100101;
    f0 = 8'b00001111;
    do_init(64, 1, 1'b1, 1'b1, 0);
    shift = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i < 8) begin
        total++; if (prn !== a5[7-i]) begin bad++; $display("FAIL rev_first i=%0d got=%b exp=%b", i, prn, a5[7-i]); end
      end
      if (i >= 32) begin
        total++; if (prn !== f0[39-i]) begin bad++; $display("FAIL rev_chip32 i=%0d got=%b exp=%b", i, prn, f0[39-i]); end
      end
    end
    shift = 1'b0;
    step();
  endtask

  task automatic test_div2_phase();
    int exp_idx [9] = '{37, 37, 38, 38, 39, 39, 0, 0, 1};
    logic [8:0] exp_prn;
    exp_prn = 9'b000000110;
    do_init(40, 2, 1'b0, 1'b1, 37);
    shift = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      total++; if (chip_idx !== LW'(exp_idx[i])) begin bad++; $display("FAIL div2_chip i=%0d got=%0d exp=%0d", i, chip_idx, exp_idx[i]); end
      total++; if (prn !== exp_prn[8-i]) begin bad++; $display("FAIL div2_prn i=%0d got=%b exp=%b", i, prn, exp_prn[8-i]); end
      total++; if (epoch !== (i == 6)) begin bad++; $display("FAIL div2_epoch i=%0d got=%b exp=%b", i, epoch, i == 6); end
    end
    shift = 1'b0;
    step();
    do_init(40, 1, 1'b0, 1'b1, 45);
    shift = 1'b1;
    step();
    total++; if (chip_idx !== '0 || epoch !== 1'b1) begin bad++; $display("FAIL phase_oob got=%0d/%b exp=0/1", chip_idx, epoch); end
    shift = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    logic [4:0] exp_prn;
    exp_prn = 5'b10100;
    do_init(5, 1, 1'b0, 1'b0, 0);
    shift = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (valid !== (i < 5)) begin bad++; $display("FAIL oneshot_valid i=%0d got=%b exp=%b", i, valid, i < 5); end
      total++; if (done !== (i == 5)) begin bad++; $display("FAIL oneshot_done i=%0d got=%b exp=%b", i, done, i == 5); end
      if (i < 5) begin
        total++; if (prn !== exp_prn[4-i]) begin bad++; $display("FAIL oneshot_prn i=%0d got=%b exp=%b", i, prn, exp_prn[4-i]); end
      end
    end
    shift = 1'b0;
    step();
  endtask

  task automatic test_taps();
    logic [2:0] exp_taps;
    logic prev, b;
    int chip;
    rst = 1'b1; step(); rst = 1'b0;
    wr_word(0, 32'h5555_5555);
    do_init(32, 1, 1'b0, 1'b1, 0);
    exp_taps = 3'b000; prev = 1'b0; chip = 0;
    for (int i = 0; i < 12; i++) begin
      shift = (i != 6);
      step();
      if (i == 6) begin
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL taps_gap_valid got=%b exp=0", valid); end
        total++; if (prn_taps !== exp_taps || prn !== prev) begin bad++; $display("FAIL taps_gap_hold got=%b/%b exp=%b/%b", prn_taps, prn, exp_taps, prev); end
      end else begin
        b = (chip % 2) == 0;
        exp_taps = {exp_taps[1:0], prev};
        prev = b;
        chip++;
        total++; if (prn !== b) begin bad++; $display("FAIL taps_prn i=%0d got=%b exp=%b", i, prn, b); end
        total++; if (prn_taps !== exp_taps) begin bad++; $display("FAIL taps_line i=%0d got=%b exp=%b", i, prn_taps, exp_taps); end
      end
    end
    shift = 1'b0;
    step();
    wr_word(0, 32'hA5A5_A5A5);
  endtask

  task automatic test_rst_midrun();
    do_init(64, 1, 1'b0, 1'b1, 0);
    shift = 1'b1;
    repeat (5) step();
    rst = 1'b1; init = 1'b1;
    step();
    total++; if ({prn, prn_taps, valid, epoch, busy, done} !== 8'b0) begin bad++; $display("FAIL rst_outputs got=%b exp=0", {prn, prn_taps, valid, epoch, busy, done}); end
    total++; if (chip_idx !== '0) begin bad++; $display("FAIL rst_chip got=%0d exp=0", chip_idx); end
    rst = 1'b0; init = 1'b0;
    repeat (3) step();
    total++; if (valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_idle got=%b/%b exp=0/0", valid, busy); end
    shift = 1'b0;
  endtask

  task automatic test_init_with_shift();
    do_init(64, 1, 1'b0, 1'b1, 0);
    shift = 1'b1;
    repeat (3) step();
    init_phase = LW'(10); init = 1'b1;
    step();
    init = 1'b0;
    total++; if (busy !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL init_load0 got=%b/%b exp=1/0", busy, valid); end
    step();
    total++; if (busy !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL init_load1 got=%b/%b exp=1/0", busy, valid); end
    step();
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL init_run_entry got=%b/%b exp=0/0", busy, valid); end
    step();
    total++; if (valid !== 1'b1 || prn !== 1'b1 || chip_idx !== LW'(10)) begin bad++; $display("FAIL init_first got=%b/%b/%0d exp=1/1/10", valid, prn, chip_idx); end
    shift = 1'b0;
    step();
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    step();
    test_reset();
    wr_word(0, 32'hA5A5_A5A5);
    wr_word(1, 32'h0F0F_0F0F);
    test_lsb_cyclic();
    test_reverse();
    test_div2_phase();
    test_oneshot();
    test_taps();
    test_rst_midrun();
    test_init_with_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
